mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, requester/cache address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max ACCESS cycles without cache_hit before error (legal range 2..255).
REQ-004 SHALL have ports: clk  in  1  single clock, all state updates on rising edge; rst  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: fetch_req in 1 PC fetch request; fetch_addr in ADDR_W fetch address (read only).
REQ-006 SHALL have ports: data_req in 1; data_addr in ADDR_W; data_wr in 1 (1=write); data_wdata in DATA_W; load/store requester.
REQ-007 SHALL have ports: dma_req in 1; dma_addr in ADDR_W; dma_wr in 1; dma_wdata in DATA_W; DMA requester.
REQ-008 SHALL have ports: cache_hit in 1 cache completion; cache_rdata in DATA_W cache read data.
REQ-009 SHALL have ports: cache_req out 1; cache_addr out ADDR_W; cache_w_rd out 1 (1=write); cache_wdata out DATA_W.
REQ-010 SHALL have ports: fetch_ack, data_ack, dma_ack out 1 each; err out 1; rdata out DATA_W; busy out 1.

Function
REQ-011 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-012 IDLE: if any req high at edge, SHALL register winner id, address, wr, wdata and go ACCESS; else stay IDLE.
REQ-013 ACCESS: SHALL drive cache_req=1 and registered addr/w_rd/wdata, held stable every ACCESS cycle.
REQ-014 ACCESS: cache_hit=1 at edge SHALL capture cache_rdata into rdata (reads only; writes leave rdata unchanged), clear err flag, go RESP.
REQ-015 ACCESS: timeout counter SHALL count ACCESS cycles; on TIMEOUT-th cycle without hit SHALL set err flag, go RESP.
REQ-016 RESP: cache_req=0; ack of granted requester only SHALL be 1 for exactly one cycle; err SHALL be 1 this cycle iff timeout; then IDLE.
REQ-017 Minimum latency: req sampled at edge k, hit at edge k+1, ack high during cycle k+1..k+2 (2 edges req-to-ack).
REQ-018 Requester SHALL hold req and operands until ack; arbiter ignores operand changes after grant.
REQ-019 Req dropped mid-transaction: transaction SHALL complete and ack still pulse; no cancel.
REQ-020 No back-to-back grant: RESP always precedes next IDLE arbitration (one idle cycle between transactions minimum).
REQ-021 busy SHALL be 1 in ACCESS and RESP, 0 in IDLE.
REQ-022 Only one ack SHALL ever be high; acks and err 0 outside RESP.
REQ-023 cache_hit in IDLE or RESP SHALL be ignored.
REQ-024 Timeout counter SHALL reset to 0 on entry to ACCESS; never wraps.

Reset
REQ-025 rst=0 at edge SHALL force IDLE from any state, including mid-ACCESS, abandoning transaction without ack.
REQ-026 Reset values: cache_req=0, cache_addr=0, cache_w_rd=0, cache_wdata=0, all acks=0, err=0, rdata=0, busy=0, counter=0, RR pointer=fetch.

Configuration
REQ-027 Macro MEM_ARB_ROUND_ROBIN_EN defined: SHALL arbitrate round-robin order fetch->data->dma, search starting after last granted id; pointer updates only on grant.
REQ-028 Macro undefined: SHALL use fixed priority data > fetch > dma; no pointer state.

Verification
REQ-029 Single fetch: fetch_req=1, addr=0x1234, hit 1 cycle after grant, rdata=0xA9 -> cache_addr=0x1234, w_rd=0, fetch_ack 1 cycle, rdata=0xA9, err=0.
REQ-030 Write: data_req=1, wr=1, addr=0x0200, wdata=0x5C -> cache_w_rd=1, cache_wdata=0x5C, data_ack pulse, rdata unchanged.
REQ-031 All three req held continuously, hit immediate -> fixed: data,data,data...; RR: fetch,data,dma,fetch order of acks.
REQ-032 No hit, TIMEOUT=15 -> cache_req high 15 cycles, then ack+err=1 one cycle, then IDLE.
REQ-033 rst=0 in 3rd ACCESS cycle -> next cycle cache_req=0, busy=0, no ack ever issued.
REQ-034 Hit pulses in IDLE / fetch_req dropped mid-ACCESS -> hit ignored; fetch_ack still pulses on later hit.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-requester (fetch / data / dma) front end for a single
// cache port. Sequencing is IDLE -> ACCESS -> RESP -> IDLE, with one grant
// per pass.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration in
// the order fetch -> data -> dma. Without it, arbitration is fixed priority
// data > fetch > dma and no pointer state exists.
//
// Every output is driven directly from a register. The next-state logic
// computes the value each output must show in the following cycle.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester (read only)
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  // load/store requester
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              data_wr,
  input  logic [DATA_W-1:0] data_wdata,
  // DMA requester
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_wr,
  input  logic [DATA_W-1:0] dma_wdata,
  // cache side
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              cache_req,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_w_rd,
  output logic [DATA_W-1:0] cache_wdata,
  // responses
  output logic              fetch_ack,
  output logic              data_ack,
  output logic              dma_ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] ID_FETCH = 2'd0;
  localparam logic [1:0] ID_DATA  = 2'd1;
  localparam logic [1:0] ID_DMA   = 2'd2;

  // TIMEOUT is at most 255, so 8 bits suffice. The counter stops at
  // CNT_LAST, the index of the last cycle allowed before an error.
  localparam int              CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cache_req_q, cache_req_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [2:0]        ack_q, ack_d;     // {dma, data, fetch}

  logic [2:0]        req_s;            // {dma, data, fetch}
  logic              any_req_s;
  logic [1:0]        win_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_wr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  assign req_s     = {dma_req, data_req, fetch_req};
  assign any_req_s = |req_s;

  // Convert a requester id into its one-hot ack vector {dma, data, fetch}.
  function automatic logic [2:0] ack_onehot(input logic [1:0] id);
    logic [2:0] v;
    case (id)
      ID_FETCH: v = 3'b001;
      ID_DATA:  v = 3'b010;
      ID_DMA:   v = 3'b100;
      default:  v = 3'b000;
    endcase
    return v;
  endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr_q holds the requester that has top priority on the next grant. It
  // resets to fetch and afterwards points one past the last winner.
  logic [1:0] ptr_q, ptr_d;

  // Circular search that begins at ptr.
  function automatic logic [1:0] pick_rr(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] id;
    case (ptr)
      ID_DATA: begin
        if (req[1])      id = ID_DATA;
        else if (req[2]) id = ID_DMA;
        else if (req[0]) id = ID_FETCH;
        else             id = ID_FETCH;
      end
      ID_DMA: begin
        if (req[2])      id = ID_DMA;
        else if (req[0]) id = ID_FETCH;
        else if (req[1]) id = ID_DATA;
        else             id = ID_FETCH;
      end
      default: begin
        if (req[0])      id = ID_FETCH;
        else if (req[1]) id = ID_DATA;
        else if (req[2]) id = ID_DMA;
        else             id = ID_FETCH;
      end
    endcase
    return id;
  endfunction

  // Return the id that follows the given one in the rotation.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    logic [1:0] n;
    case (id)
      ID_FETCH: n = ID_DATA;
      ID_DATA:  n = ID_DMA;
      ID_DMA:   n = ID_FETCH;
      default:  n = ID_FETCH;
    endcase
    return n;
  endfunction

  assign win_s = pick_rr(req_s, ptr_q);

  // Move the pointer only when a grant is actually issued.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && any_req_s) begin
      ptr_d = next_id(win_s);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= ID_FETCH;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: data > fetch > dma.
  function automatic logic [1:0] pick_fixed(input logic [2:0] req);
    logic [1:0] id;
    if (req[1])      id = ID_DATA;
    else if (req[0]) id = ID_FETCH;
    else if (req[2]) id = ID_DMA;
    else             id = ID_FETCH;
    return id;
  endfunction

  assign win_s = pick_fixed(req_s);
`endif

  // Select the operands of the candidate winner. A fetch is always a read
  // with zero write data.
  always_comb begin
    sel_addr_s  = fetch_addr;
    sel_wr_s    = 1'b0;
    sel_wdata_s = {DATA_W{1'b0}};
    case (win_s)
      ID_DATA: begin
        sel_addr_s  = data_addr;
        sel_wr_s    = data_wr;
        sel_wdata_s = data_wdata;
      end
      ID_DMA: begin
        sel_addr_s  = dma_addr;
        sel_wr_s    = dma_wr;
        sel_wdata_s = dma_wdata;
      end
      default: begin
        sel_addr_s  = fetch_addr;
        sel_wr_s    = 1'b0;
        sel_wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Next state, plus the registered value every output takes next cycle.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    cache_req_d = 1'b0;
    busy_d      = 1'b0;
    err_d       = 1'b0;
    ack_d       = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          // Latch the grant. Operand changes after this point are ignored.
          state_d     = ST_ACCESS;
          gnt_d       = win_s;
          addr_d      = sel_addr_s;
          wr_d        = sel_wr_s;
          wdata_d     = sel_wdata_s;
          cnt_d       = {CNT_W{1'b0}};
          cache_req_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        busy_d = 1'b1;
        if (cache_hit) begin
          state_d = ST_RESP;
          ack_d   = ack_onehot(gnt_q);
          err_d   = 1'b0;
          if (!wr_q) begin
            rdata_d = cache_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          // This is the last allowed ACCESS cycle and no hit arrived.
          state_d = ST_RESP;
          ack_d   = ack_onehot(gnt_q);
          err_d   = 1'b1;
        end else begin
          state_d     = ST_ACCESS;
          cnt_d       = cnt_q + 8'd1;
          cache_req_d = 1'b1;
        end
      end
      ST_RESP: begin
        // Spend one cycle here so no two grants are ever back to back.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= ID_FETCH;
      addr_q      <= {ADDR_W{1'b0}};
      wr_q        <= 1'b0;
      wdata_q     <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      cache_req_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      cache_req_q <= cache_req_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
    end
  end

  assign cache_req   = cache_req_q;
  assign cache_addr  = addr_q;
  assign cache_w_rd  = wr_q;
  assign cache_wdata = wdata_q;
  assign fetch_ack   = ack_q[0];
  assign data_ack    = ack_q[1];
  assign dma_ack     = ack_q[2];
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;

endmodule
